traffic_conflict_monitor: RTL
=============================

// Module: traffic_conflict_monitor
// PURPOSE
//   Fail-safe stage between the traffic controller's light outputs A/B/C/D and the lamp drivers.
//   Registers the four 3-bit light codes and checks each cycle for illegal codes,
//   conflicting approaches, illegal sequencing and short green/yellow dwell times.
//   With no violation, codes pass through unchanged.
//   On the first violation, latches a fault code and drives flashing all-red until cleared.
// PARAMETERS
//   MIN_GREEN   30  minimum cycles a green may be held before turning yellow
//   MIN_YELLOW  10  minimum cycles a yellow may be held before turning red
//   FLASH_HALF   8  cycles per half-period of the fault flash (red / dark)
// PORTS
//   clk         in   1  system clock, all logic on rising edge
//   rst_n       in   1  asynchronous active-low reset
//   a_in..d_in  in   3  light codes from controller: 100 green, 010 yellow, 001 red
//   fault_clr   in   1  request to leave FAULT (single-cycle pulse or level)
//   a_out..d_out out 3  codes to lamp drivers
//   fault       out  1  1 while in FAULT
//   fault_code  out  3  first violation seen: 0 none, 1..5 below
// BEHAVIOUR
//   Reset, asynchronous:
//     - a_out..d_out = 001; fault = 0; fault_code = 0; state = MONITOR
//     - Input regs and prev codes = 001; dwell counters = 0
//   Pipeline:
//     - Edge k: inputs captured into in_q.
//     - Edge k+1: in_q checked and outputs updated. Total latency 2 cycles.
//     - A violating in_q never reaches the outputs.
//   Dwell counter, one per approach:
//     - Compares in_q with prev code. Set to 1 on change, else +1.
//     - Saturates at MIN_GREEN; width clog2(MIN_GREEN+1).
//   Checks in MONITOR; the lowest code number wins when several hit in one cycle:
//     1 illegal code: any in_q not in {100, 010, 001}
//     2 conflict: more than one approach not 001
//     3 illegal transition: 100->001, 010->100 or 001->010 on any approach
//     4 short green: 100->010 with dwell < MIN_GREEN
//     5 short yellow: 010->001 with dwell < MIN_YELLOW
//   FSM:
//     - MONITOR, no violation: outputs <= in_q; prev <= in_q; counters update.
//     - MONITOR, violation: -> FAULT. fault <= 1; fault_code <= winning code.
//       Outputs <= all 001; flash counter cleared.
//     - FAULT outputs: all 001 for FLASH_HALF cycles, then all 000 for FLASH_HALF cycles, repeating.
//     - FAULT: further violations ignored; fault_code held.
//     - FAULT exit: fault_clr=1 and all four in_q == 001 -> MONITOR on that edge.
//       fault <= 0; fault_code <= 0; outputs <= 001; prev <= 001; dwell <= 0.
//     - fault_clr with any in_q not red: ignored, stay in FAULT.
//     - fault_clr while in MONITOR: no effect, including on the cycle a fault is detected.
//   Reset asserted mid-flash or mid-check returns to reset values immediately.
// TESTING
//   1. Reset, then drive the nominal sequence (A G30/Y10, B G30/Y10, C, D) for 2 rounds
//      -> outputs equal inputs delayed 2 cycles; fault stays 0.
//   2. Drive a_in=100 and c_in=100 together -> fault=1, fault_code=2.
//      Outputs never show two greens; all 001 for 8 cycles, then 000 for 8, repeating.
//   3. A green 30 cycles, then a_in=001 directly -> fault_code=3.
//      Separately, b_in 001->010 -> fault_code=3.
//   4. A green 29 cycles then 010 -> fault_code=4.
//      After reset, green 30 then yellow 9 then 001 -> fault_code=5.
//   5. b_in=011 in the same cycle as a two-green conflict -> fault_code=1 (priority).
//   6. In FAULT, fault_clr=1 with a_in=100 -> stays FAULT.
//      fault_clr=1 with all 001 -> fault=0 after 1 edge; outputs track again.
//      rst_n low mid-flash -> outputs 001 at once.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
`default_nettype none
// =============================================================================
// Module      : traffic_conflict_monitor
// Description : Fail-safe checker between signal controller and lamp drivers.
// Revision    : 1.0
// =============================================================================
module traffic_conflict_monitor #(
    parameter int MIN_GREEN  = 30,
    parameter int MIN_YELLOW = 10,
    parameter int FLASH_HALF = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] a_in,
    input  logic [2:0] b_in,
    input  logic [2:0] c_in,
    input  logic [2:0] d_in,
    input  logic       fault_clr,
    output logic [2:0] a_out,
    output logic [2:0] b_out,
    output logic [2:0] c_out,
    output logic [2:0] d_out,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int DW = $clog2(MIN_GREEN + 1);
    localparam int FW = $clog2(2 * FLASH_HALF);

    localparam logic [2:0]    C_GREEN      = 3'b100;
    localparam logic [2:0]    C_YELLOW     = 3'b010;
    localparam logic [2:0]    C_RED        = 3'b001;
    localparam logic [2:0]    C_DARK       = 3'b000;
    localparam logic [DW-1:0] C_MIN_GREEN  = DW'(MIN_GREEN);
    localparam logic [DW-1:0] C_MIN_YELLOW = DW'(MIN_YELLOW);
    localparam logic [FW-1:0] C_FLASH_HALF = FW'(FLASH_HALF);
    localparam logic [FW-1:0] C_FLASH_LAST = FW'(2 * FLASH_HALF - 1);

    typedef enum logic [0:0] {
        MONITOR = 1'b0,
        FAULT   = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Lane index 0..3 corresponds to approaches A..D.
    logic [3:0][2:0]    r_in_q;
    logic [3:0][2:0]    r_prev;
    logic [3:0][2:0]    r_out;
    logic [3:0][DW-1:0] r_dwell;
    logic [FW-1:0]      r_flash;
    logic               r_fault;
    logic [2:0]         r_code;

    logic [3:0][2:0]    w_out_next;
    logic [3:0][2:0]    w_prev_next;
    logic [3:0][DW-1:0] w_dwell_next;
    logic [3:0][DW-1:0] w_dwell_inc;
    logic [FW-1:0]      w_flash_next;
    logic               w_fault_next;
    logic [2:0]         w_code_next;

    logic [3:0] w_illegal;
    logic [3:0] w_active;
    logic [3:0] w_bad_trans;
    logic [3:0] w_short_g;
    logic [3:0] w_short_y;
    logic       w_conflict;
    logic       w_all_red;
    logic [2:0] w_viol;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_illegal[i]   = !((r_in_q[i] == C_GREEN) || (r_in_q[i] == C_YELLOW) ||
                                  (r_in_q[i] == C_RED));
        assign w_active[i]    = (r_in_q[i] != C_RED);
        assign w_bad_trans[i] = ((r_prev[i] == C_GREEN)  && (r_in_q[i] == C_RED))    ||
                                ((r_prev[i] == C_YELLOW) && (r_in_q[i] == C_GREEN))  ||
                                ((r_prev[i] == C_RED)    && (r_in_q[i] == C_YELLOW));
        assign w_short_g[i]   = (r_prev[i] == C_GREEN) && (r_in_q[i] == C_YELLOW) &&
                                (r_dwell[i] < C_MIN_GREEN);
        assign w_short_y[i]   = (r_prev[i] == C_YELLOW) && (r_in_q[i] == C_RED) &&
                                (r_dwell[i] < C_MIN_YELLOW);
        assign w_dwell_inc[i] = (r_in_q[i] != r_prev[i]) ? DW'(1) :
                                (r_dwell[i] == C_MIN_GREEN) ? r_dwell[i] :
                                r_dwell[i] + DW'(1);
    end

    // x & (x-1) is non-zero exactly when two or more lanes are active.
    assign w_conflict = |(w_active & (w_active - 4'd1));
    assign w_all_red  = ~|w_active;

    always_comb begin
        w_viol = 3'd0;
        if (|w_illegal) begin
            w_viol = 3'd1;
        end else if (w_conflict) begin
            w_viol = 3'd2;
        end else if (|w_bad_trans) begin
            w_viol = 3'd3;
        end else if (|w_short_g) begin
            w_viol = 3'd4;
        end else if (|w_short_y) begin
            w_viol = 3'd5;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_out_next   = r_out;
        w_prev_next  = r_prev;
        w_dwell_next = r_dwell;
        w_flash_next = r_flash;
        w_fault_next = r_fault;
        w_code_next  = r_code;
        if (r_state == MONITOR) begin
            if (w_viol != 3'd0) begin
                w_state_next = FAULT;
                w_fault_next = 1'b1;
                w_code_next  = w_viol;
                w_out_next   = {4{C_RED}};
                w_flash_next = '0;
            end else begin
                w_out_next   = r_in_q;
                w_prev_next  = r_in_q;
                w_dwell_next = w_dwell_inc;
            end
        end else begin
            if (fault_clr && w_all_red) begin
                w_state_next = MONITOR;
                w_fault_next = 1'b0;
                w_code_next  = 3'd0;
                w_out_next   = {4{C_RED}};
                w_prev_next  = {4{C_RED}};
                w_dwell_next = '0;
                w_flash_next = '0;
            end else begin
                w_flash_next = (r_flash == C_FLASH_LAST) ? '0 : r_flash + FW'(1);
                w_out_next   = (w_flash_next < C_FLASH_HALF) ? {4{C_RED}} : {4{C_DARK}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MONITOR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_q  <= {4{C_RED}};
            r_prev  <= {4{C_RED}};
            r_out   <= {4{C_RED}};
            r_dwell <= '0;
            r_flash <= '0;
            r_fault <= 1'b0;
            r_code  <= 3'd0;
        end else begin
            r_in_q  <= {d_in, c_in, b_in, a_in};
            r_prev  <= w_prev_next;
            r_out   <= w_out_next;
            r_dwell <= w_dwell_next;
            r_flash <= w_flash_next;
            r_fault <= w_fault_next;
            r_code  <= w_code_next;
        end
    end

    assign a_out      = r_out[0];
    assign b_out      = r_out[1];
    assign c_out      = r_out[2];
    assign d_out      = r_out[3];
    assign fault      = r_fault;
    assign fault_code = r_code;

endmodule
`default_nettype wire
